// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: 16/32-bit accesses to a 16-bit data memory over req/ack.
// Optional watchdog per halfword access enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_AW  = 12,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ex_valid,
  output logic              o_ex_ready,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_wide,
  input  logic [ADDR_W-1:0] i_ex_addr,
  input  logic [31:0]       i_ex_wdata,
  output logic              o_dm_req,
  output logic              o_dm_we,
  output logic [MEM_AW-1:0] o_dm_addr,
  output logic [15:0]       o_dm_wdata,
  input  logic              i_dm_ack,
  input  logic [15:0]       i_dm_rdata,
  output logic              o_wb_valid,
  output logic [31:0]       o_wb_data,
  output logic              o_fault
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [MEM_AW-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_wide, r_write, r_fault;
  logic [15:0]       r_lo;
  logic [31:0]       r_wb_data;

  logic              w_accept, w_range_err, w_timeout, w_fault_d;
  logic [15:0]       w_lo_d;
  logic [31:0]       w_wb_data_d;

  if (TIMEOUT == 0 || MEM_AW >= ADDR_W) begin : g_param_err
    $error("mem_access_unit: invalid parameters");
  end

  assign o_ex_ready  = (r_state == StIdle) && i_rst;
  assign w_accept    = i_ex_valid && o_ex_ready;
  assign w_range_err = |i_ex_addr[ADDR_W-1:MEM_AW];

  always_comb begin
    w_state_d   = r_state;
    w_fault_d   = r_fault;
    w_lo_d      = r_lo;
    w_wb_data_d = r_wb_data;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (!i_mem_read && !i_mem_write) begin
            w_state_d   = StDone;
            w_fault_d   = 1'b0;
            w_wb_data_d = {{16{i_ex_wdata[15]}}, i_ex_wdata[15:0]};
          end else if ((i_mem_read && i_mem_write) || w_range_err) begin
            w_state_d   = StDone;
            w_fault_d   = 1'b1;
            w_wb_data_d = '0;
          end else begin
            w_state_d = StLo;
          end
        end
      end
      StLo: begin
        if (i_dm_ack) begin
          w_lo_d = i_dm_rdata;
          if (r_wide) begin
            w_state_d = StHi;
          end else begin
            w_state_d   = StDone;
            w_fault_d   = 1'b0;
            w_wb_data_d = r_write ? 32'd0 : {{16{i_dm_rdata[15]}}, i_dm_rdata};
          end
        end else if (w_timeout) begin
          w_state_d   = StDone;
          w_fault_d   = 1'b1;
          w_wb_data_d = '0;
        end
      end
      StHi: begin
        if (i_dm_ack) begin
          w_state_d   = StDone;
          w_fault_d   = 1'b0;
          w_wb_data_d = r_write ? 32'd0 : {i_dm_rdata, r_lo};
        end else if (w_timeout) begin
          w_state_d   = StDone;
          w_fault_d   = 1'b1;
          w_wb_data_d = '0;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wide    <= 1'b0;
      r_write   <= 1'b0;
      r_fault   <= 1'b0;
      r_lo      <= '0;
      r_wb_data <= '0;
    end else begin
      r_state   <= w_state_d;
      r_fault   <= w_fault_d;
      r_lo      <= w_lo_d;
      r_wb_data <= w_wb_data_d;
      if (w_accept) begin
        r_addr  <= i_ex_addr[MEM_AW-1:0];
        r_wdata <= i_ex_wdata;
        r_wide  <= i_wide;
        r_write <= i_mem_write;
      end
    end
  end

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] r_cnt;

  // Restarts on every state change, so each halfword gets a fresh budget.
  always_ff @(posedge i_clk) begin
    if (!i_rst || (r_state != w_state_d)) begin
      r_cnt <= '0;
    end else if (o_dm_req) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign w_timeout = o_dm_req && (r_cnt == CntW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    o_dm_req   = 1'b0;
    o_dm_addr  = '0;
    o_dm_wdata = '0;
    unique case (r_state)
      StLo: begin
        o_dm_req   = 1'b1;
        o_dm_addr  = r_addr;
        o_dm_wdata = r_wdata[15:0];
      end
      StHi: begin
        o_dm_req   = 1'b1;
        o_dm_addr  = r_addr + MEM_AW'(1);
        o_dm_wdata = r_wdata[31:16];
      end
      default: ;
    endcase
  end

  assign o_dm_we    = o_dm_req && r_write;
  assign o_wb_valid = (r_state == StDone);
  assign o_wb_data  = r_wb_data;
  assign o_fault    = o_wb_valid && r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, mem_read, mem_write, wide;
  logic [31:0] ex_addr, ex_wdata;
  logic        dm_req, dm_we, dm_ack;
  logic [11:0] dm_addr;
  logic [15:0] dm_wdata, dm_rdata;
  logic        wb_valid, fault;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(
    .ADDR_W (32),
    .MEM_AW (12),
    .TIMEOUT(15)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ex_valid (ex_valid),
    .o_ex_ready (ex_ready),
    .i_mem_read (mem_read),
    .i_mem_write(mem_write),
    .i_wide     (wide),
    .i_ex_addr  (ex_addr),
    .i_ex_wdata (ex_wdata),
    .o_dm_req   (dm_req),
    .o_dm_we    (dm_we),
    .o_dm_addr  (dm_addr),
    .o_dm_wdata (dm_wdata),
    .i_dm_ack   (dm_ack),
    .i_dm_rdata (dm_rdata),
    .o_wb_valid (wb_valid),
    .o_wb_data  (wb_data),
    .o_fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one operation and steps over the accepting edge.
  task automatic issue(input logic rd, input logic wr, input logic wd,
                       input logic [31:0] addr, input logic [31:0] wdat);
    chk("ready_before_issue", {31'd0, ex_ready}, 32'd1);
    ex_valid  = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    wide      = wd;
    ex_addr   = addr;
    ex_wdata  = wdat;
    tick();
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wide      = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; wide = 1'b0;
    ex_addr = '0; ex_wdata = '0; dm_ack = 1'b0; dm_rdata = '0;
    tick();
    tick();
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst_dm_addr", {20'd0, dm_addr}, 32'd0);
    chk("rst_dm_wdata", {16'd0, dm_wdata}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    rst = 1'b1;
    #1;

    // Narrow store, zero-wait ack
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_1234);
    chk("st_req", {31'd0, dm_req}, 32'd1);
    chk("st_we", {31'd0, dm_we}, 32'd1);
    chk("st_addr", {20'd0, dm_addr}, 32'h005);
    chk("st_wdata", {16'd0, dm_wdata}, 32'h1234);
    chk("st_busy", {31'd0, ex_ready}, 32'd0);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("st_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("st_wb_data", wb_data, 32'd0);
    chk("st_fault", {31'd0, fault}, 32'd0);
    chk("st_req_done", {31'd0, dm_req}, 32'd0);
    tick();
    chk("st_wb_pulse", {31'd0, wb_valid}, 32'd0);

    // Narrow load with 3 wait cycles
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait_req", {31'd0, dm_req}, 32'd1);
      chk("ld_wait_addr", {20'd0, dm_addr}, 32'h010);
      tick();
    end
    chk("ld_req4", {31'd0, dm_req}, 32'd1);
    chk("ld_we", {31'd0, dm_we}, 32'd0);
    dm_ack = 1'b1; dm_rdata = 16'h8001;
    tick();
    dm_ack = 1'b0;
    chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ld_wb_data", wb_data, 32'hFFFF_8001);
    chk("ld_fault", {31'd0, fault}, 32'd0);
    tick();

    // Wide load wrapping at top of memory
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0FFF, 32'h0);
    chk("wl_addr_lo", {20'd0, dm_addr}, 32'hFFF);
    dm_ack = 1'b1; dm_rdata = 16'hBEEF;
    tick();
    chk("wl_req_hi", {31'd0, dm_req}, 32'd1);
    chk("wl_addr_hi", {20'd0, dm_addr}, 32'h000);
    chk("wl_no_wb", {31'd0, wb_valid}, 32'd0);
    dm_rdata = 16'hDEAD;
    tick();
    dm_ack = 1'b0;
    chk("wl_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("wl_wb_data", wb_data, 32'hDEAD_BEEF);
    tick();
    chk("wl_wb_held", wb_data, 32'hDEAD_BEEF);

    // Range fault on a negative address
    issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("rf_req", {31'd0, dm_req}, 32'd0);
    chk("rf_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("rf_fault", {31'd0, fault}, 32'd1);
    chk("rf_wb_data", wb_data, 32'd0);
    tick();

    // Pass-through, sign-extended
    issue(1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'h5555_8000);
    chk("pt_req", {31'd0, dm_req}, 32'd0);
    chk("pt_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("pt_wb_data", wb_data, 32'hFFFF_8000);
    chk("pt_fault", {31'd0, fault}, 32'd0);
    tick();

    // Illegal read+write
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_7777);
    chk("il_req", {31'd0, dm_req}, 32'd0);
    chk("il_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("il_fault", {31'd0, fault}, 32'd1);
    chk("il_wb_data", wb_data, 32'd0);
    tick();

    // First address above physical range
    issue(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0001);
    chk("rb_req", {31'd0, dm_req}, 32'd0);
    chk("rb_fault", {31'd0, fault}, 32'd1);
    tick();

    // Wide store, little-endian halves
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_5678);
    chk("ws_addr_lo", {20'd0, dm_addr}, 32'h020);
    chk("ws_wdata_lo", {16'd0, dm_wdata}, 32'h5678);
    dm_ack = 1'b1;
    tick();
    chk("ws_addr_hi", {20'd0, dm_addr}, 32'h021);
    chk("ws_wdata_hi", {16'd0, dm_wdata}, 32'hCAFE);
    chk("ws_we_hi", {31'd0, dm_we}, 32'd1);
    tick();
    dm_ack = 1'b0;
    chk("ws_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ws_wb_data", wb_data, 32'd0);
    tick();

    // Reset during LO with ack withheld, then late ack
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'h0);
    chk("ra_req", {31'd0, dm_req}, 32'd1);
    rst = 1'b0;
    tick();
    chk("ra_req_drop", {31'd0, dm_req}, 32'd0);
    chk("ra_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("ra_not_ready", {31'd0, ex_ready}, 32'd0);
    rst = 1'b1; dm_ack = 1'b1; dm_rdata = 16'h1111;
    tick();
    dm_ack = 1'b0;
    chk("ra_late_ack_wb", {31'd0, wb_valid}, 32'd0);
    chk("ra_late_ack_req", {31'd0, dm_req}, 32'd0);
    chk("ra_ready", {31'd0, ex_ready}, 32'd1);

    // Ack never arrives
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
`ifdef MAU_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      chk("to_req_high", {31'd0, dm_req}, 32'd1);
      tick();
    end
    chk("to_req_drop", {31'd0, dm_req}, 32'd0);
    chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_wb_data", wb_data, 32'd0);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("noto_req_high", {31'd0, dm_req}, 32'd1);
    chk("noto_no_wb", {31'd0, wb_valid}, 32'd0);
`endif
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit: consumes the execute stage's 16-bit result, 32-bit sign-extended address and memory-control bits, and performs the corresponding load/store against the 16-bit data memory over a req/ack handshake. It performs 16-bit and 32-bit (two-halfword) accesses, stalls the upstream pipeline while busy, and presents retired results to writeback.

## Interface
- ADDR_W, 32: width of the address from execute.
- MEM_AW, 12: physical halfword-address width of data memory.
- TIMEOUT, 15: watchdog limit in cycles per halfword access (see Configuration).

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- ex_valid  in  1  execute result valid this cycle.
- ex_ready  out  1  unit can accept; transfer when ex_valid && ex_ready.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- wide  in  1  32-bit access (two halfwords).
- ex_addr  in  ADDR_W  halfword address.
- ex_wdata  in  32  store data; [15:0] only when narrow; also pass-through ALU result in [15:0].
- dm_req  out  1  memory request.
- dm_we  out  1  memory write enable.
- dm_addr  out  MEM_AW  memory address.
- dm_wdata  out  16  memory write data.
- dm_ack  in  1  memory completes current request.
- dm_rdata  in  16  read data, valid with dm_ack.
- wb_valid  out  1  one-cycle retire pulse.
- wb_data  out  32  retired result.
- fault  out  1  with wb_valid: access aborted.

## Operation
- States: IDLE, LO, HI, DONE. ex_ready = (state==IDLE) && rst.
- Accept in IDLE: latch addr, wdata, wide, read/write.
  - Neither read nor write: pass-through -> DONE; wb_data = sign-extend ex_wdata[15:0].
  - Both read and write: illegal -> DONE with fault, wb_data 0, no dm_req.
  - ex_addr[ADDR_W-1:MEM_AW] nonzero (includes all negative addresses): range fault -> DONE with fault, no dm_req.
  - Otherwise -> LO.
- LO: dm_req=1, dm_addr=addr[MEM_AW-1:0], dm_wdata=wdata[15:0], dm_we=write. On dm_ack: read captures dm_rdata into low half; wide -> HI, narrow -> DONE.
- HI: dm_addr=addr+1 modulo 2^MEM_AW (wraps to 0 at top), dm_wdata=wdata[31:16]; on dm_ack capture high half -> DONE. Little-endian: low halfword at lower address.
- DONE: wb_valid=1 one cycle, -> IDLE.
- wb_data: narrow load = sign-extended halfword; wide load = {hi,lo}; store = 0; fault = 0. Held until next DONE.
- dm_req/dm_addr/dm_we/dm_wdata decoded from registered state and latched operands only; stable while dm_req high. dm_ack with dm_req low ignored.

## Timing
- Reset values: ex_ready 0 during reset, dm_req 0, dm_we 0, dm_addr 0, dm_wdata 0, wb_valid 0, wb_data 0, fault 0, state IDLE.
- Accept at edge T. Pass-through/fault: wb_valid cycle T+1.
- Narrow, zero-wait ack: dm_req cycles T+1; wb_valid T+2; ex_ready again T+3.
- Wide, zero-wait: LO at T+1, HI at T+2, wb_valid T+3.
- Each cycle dm_ack is withheld adds one cycle; dm_req stays high.
- Reset asserted mid-access: next edge returns to IDLE, dm_req drops, no wb_valid; late dm_ack ignored.
- Back-to-back: at most one operation in flight; throughput one per (latency+1) cycles.

## Configuration
- MAU_TIMEOUT_EN defined: per-halfword counter clears on entering LO/HI; if dm_ack not seen within TIMEOUT cycles in state, dm_req drops, -> DONE with fault=1, wb_data 0; partial wide store not rolled back.
- Undefined: no counter; unit waits for dm_ack indefinitely.

## Test plan
- Narrow store addr 0x0005, wdata 0x1234, immediate ack -> dm_we=1, dm_addr 0x005, dm_wdata 0x1234 at T+1; wb_valid T+2, wb_data 0, fault 0.
- Narrow load addr 0x0010, memory returns 0x8001 after 3 wait cycles -> dm_req high 4 cycles, wb_data 0xFFFF8001, wb_valid at T+5.
- Wide load addr 0x0FFF (MEM_AW=12), lo 0xBEEF, hi 0xDEAD -> second dm_addr 0x000, wb_data 0xDEADBEEF at T+3.
- ex_addr 0xFFFFFFF0 load, and mem_read=mem_write=1 at 0x0001 -> no dm_req, wb_valid T+1, fault 1, wb_data 0.
- Pass-through wdata[15:0]=0x8000 -> wb_data 0xFFFF8000 at T+1; rst low during LO with ack held off -> dm_req 0 next cycle, no wb_valid.
- MAU_TIMEOUT_EN, TIMEOUT=15, no ack -> dm_req falls after 15 cycles, fault+wb_valid pulse; without macro, dm_req still high after 100 cycles.
